// File: rtl/display_scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// display_scan_mux_pkg : shared display constants, digit index type, anode table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package display_scan_mux_pkg;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam int         NUM_DIGITS = 4;
  localparam int         DIG_W      = $clog2(NUM_DIGITS);

  typedef enum logic [DIG_W-1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Active-low one-hot anode pattern for each digit slot
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_e d);
    logic [NUM_DIGITS-1:0] an;
    case (d)
      DIG3:    an = 4'b0111;
      DIG2:    an = 4'b1011;
      DIG1:    an = 4'b1101;
      DIG0:    an = 4'b1110;
      default: an = ANODE_OFF;
    endcase
    return an;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_mux_if.sv
// ---------------------------------------------------------------------------
// display_scan_mux_if : value-load handshake and scan outputs of the display mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface display_scan_mux_if;
  logic [15:0] bcd_in;
  logic        load;
  logic        pending;
  logic        loaded;
  logic        frame_tick;
  logic [3:0]  an;
  logic [3:0]  bcd;

  modport master (
    output bcd_in, load,
    input  pending, loaded, frame_tick, an, bcd
  );

  modport slave (
    input  bcd_in, load,
    output pending, loaded, frame_tick, an, bcd
  );
endinterface

`default_nettype wire

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler : free-running 0..REFRESH_DIV-1 counter, one-cycle tick at wrap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick_o
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign slot_tick_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (slot_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux : 4-digit BCD scan mux with frame-synchronous double buffering
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_mux_if.slave   disp
);

  logic        slot_tick;
  logic        frame_bnd;
  digit_e      idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic        pending_q, pending_d;
  logic        loaded_q, loaded_d;
  logic        frame_tick_q;
  logic [3:0]  an_q, an_d;
  logic [3:0]  bcd_q, bcd_d;
  logic [3:0]  blank;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .slot_tick_o (slot_tick)
  );

  assign frame_bnd = slot_tick && (idx_q == DIG0);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= DIG3;
      disp_q       <= '0;
      pend_val_q   <= '0;
      pending_q    <= 1'b0;
      loaded_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= ANODE_OFF;
      bcd_q        <= '0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_val_q   <= pend_val_d;
      pending_q    <= pending_d;
      loaded_q     <= loaded_d;
      frame_tick_q <= frame_bnd;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (slot_tick) begin
      case (idx_q)
        DIG3:    idx_d = DIG2;
        DIG2:    idx_d = DIG1;
        DIG1:    idx_d = DIG0;
        default: idx_d = DIG3;
      endcase
    end
  end

  // A load on the boundary edge still applies the old value; the new one stays pending
  always_comb begin
    disp_d     = disp_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    loaded_d   = 1'b0;
    if (frame_bnd && pending_q) begin
      disp_d    = pend_val_q;
      loaded_d  = 1'b1;
      pending_d = 1'b0;
    end
    if (disp.load) begin
      pend_val_d = disp.bcd_in;
      pending_d  = 1'b1;
    end
  end

  assign blank[0] = 1'b0;
  assign blank[3] = (BLANK_LZ != 0) && (disp_q[15:12] == 4'd0);
  assign blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
  assign blank[1] = blank[2] && (disp_q[7:4] == 4'd0);

  always_comb begin
    an_d  = anode_sel(idx_q);
    bcd_d = disp_q[{idx_q, 2'b00} +: 4];
    if (blank[idx_q]) begin
      an_d  = ANODE_OFF;
      bcd_d = '0;
    end
  end

  assign disp.pending    = pending_q;
  assign disp.loaded     = loaded_q;
  assign disp.frame_tick = frame_tick_q;
  assign disp.an         = an_q;
  assign disp.bcd        = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_display_scan_mux : directed bench, one DUT without and one with zero blanking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_mux;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;

  bit          sched_en  [16];
  logic [15:0] sched_val [16];

  display_scan_mux_if if_nb ();
  display_scan_mux_if if_lz ();

  display_scan_mux #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_dut_nb (
    .clk  (clk),
    .rst  (rst),
    .disp (if_nb)
  );

  display_scan_mux #(.REFRESH_DIV(4), .BLANK_LZ(1)) u_dut_lz (
    .clk  (clk),
    .rst  (rst),
    .disp (if_lz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] v);
    if_nb.load   = ld;
    if_lz.load   = ld;
    if_nb.bcd_in = v;
    if_lz.bcd_in = v;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 16; i++) begin
      sched_en[i]  = 1'b0;
      sched_val[i] = 16'h0;
    end
  endtask

  // Expected {an, bcd} for digit k of value v
  function automatic logic [7:0] exp_digit(input logic [15:0] v, input int k, input bit blz);
    logic [15:0] upper;
    logic [3:0]  an;
    upper = v >> (4 * k);
    an    = ~(4'b0001 << k);
    if (blz && (k != 0) && (upper == 16'h0)) return {4'hF, 4'h0};
    return {an, v[4*k +: 4]};
  endfunction

  task automatic check_status(input string tag, input bit p, input bit l, input bit ft);
    chk({tag, ".nb.pend/load/tick"}, {13'h0, if_nb.pending, if_nb.loaded, if_nb.frame_tick}, {13'h0, p, l, ft});
    chk({tag, ".lz.pend/load/tick"}, {13'h0, if_lz.pending, if_lz.loaded, if_lz.frame_tick}, {13'h0, p, l, ft});
  endtask

  task automatic check_digit(input string tag, input logic [15:0] v, input int k);
    chk({tag, ".nb.an/bcd"}, {8'h0, if_nb.an, if_nb.bcd}, {8'h0, exp_digit(v, k, 1'b0)});
    chk({tag, ".lz.an/bcd"}, {8'h0, if_lz.an, if_lz.bcd}, {8'h0, exp_digit(v, k, 1'b1)});
  endtask

  // Entered on the frame_tick negedge; walks one full frame, applying scheduled loads
  task automatic scan_frame(input string tag, input logic [15:0] v, input bit pend_in);
    bit p;
    bit hit;
    p = pend_in;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hit = (i > 0) && sched_en[i-1];
      if (i < 15) begin
        if (hit) p = 1'b1;
        check_status(tag, p, 1'b0, 1'b0);
      end else begin
        check_status(tag, hit, p, 1'b1);
      end
      check_digit(tag, v, 3 - i / 4);
      drive(sched_en[i], sched_val[i]);
    end
    clear_sched();
  endtask

  task automatic wait_frame(input string tag, input bit exp_pend, input bit exp_loaded, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!if_nb.frame_tick && cycles < 40);
    check_status(tag, exp_pend, exp_loaded, 1'b1);
  endtask

  initial begin
    clear_sched();
    drive(1'b0, 16'h0);
    rst = 1'b1;

    // Reset held three cycles, then one cycle after release
    repeat (3) begin
      @(negedge clk);
      check_status("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.nb.an/bcd", {8'h0, if_nb.an, if_nb.bcd}, 16'h00F0);
      chk("rst.lz.an/bcd", {8'h0, if_lz.an, if_lz.bcd}, 16'h00F0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_status("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.lz.an/bcd", {8'h0, if_lz.an, if_lz.bcd}, 16'h00F0);

    // First value goes live at the first frame boundary
    drive(1'b1, 16'h1234);
    @(negedge clk);
    drive(1'b0, 16'h0);
    check_status("load1234", 1'b1, 1'b0, 1'b0);
    wait_frame("first_bnd", 1'b0, 1'b1, n);
    chk("first_bnd.latency", 16'(n), 16'd14);
    scan_frame("show1234", 16'h1234, 1'b0);

    // Mid-frame load must not tear the frame being shown
    sched_en[6] = 1'b1; sched_val[6] = 16'h5678;
    scan_frame("mid5678", 16'h1234, 1'b0);
    sched_en[3] = 1'b1; sched_val[3] = 16'h0042;
    scan_frame("show5678", 16'h5678, 1'b0);

    // Leading-zero blanking patterns
    sched_en[2] = 1'b1; sched_val[2] = 16'h0000;
    scan_frame("show0042", 16'h0042, 1'b0);
    sched_en[2] = 1'b1; sched_val[2] = 16'h00A5;
    scan_frame("show0000", 16'h0000, 1'b0);

    // Last write wins; load on the boundary edge stays pending for the next frame
    sched_en[1]  = 1'b1; sched_val[1]  = 16'h1111;
    sched_en[5]  = 1'b1; sched_val[5]  = 16'h2222;
    sched_en[14] = 1'b1; sched_val[14] = 16'h3333;
    scan_frame("show00A5", 16'h00A5, 1'b0);
    scan_frame("show2222", 16'h2222, 1'b1);
    scan_frame("show3333", 16'h3333, 1'b0);

    // Reset during the digit1 slot with a value pending discards it
    drive(1'b1, 16'h9999);
    @(negedge clk);
    drive(1'b0, 16'h0);
    repeat (8) @(negedge clk);
    check_status("pre_rst", 1'b1, 1'b0, 1'b0);
    check_digit("pre_rst", 16'h3333, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_status("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst.nb.an/bcd", {8'h0, if_nb.an, if_nb.bcd}, 16'h00F0);
    chk("mid_rst.lz.an/bcd", {8'h0, if_lz.an, if_lz.bcd}, 16'h00F0);
    wait_frame("rst_bnd", 1'b0, 1'b0, n);
    chk("rst_bnd.latency", 16'(n), 16'd16);
    scan_frame("after_rst", 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
